store_narrow_unit: RTL and testbench

- Store-side counterpart of the datapath's 16→32 sign extension: narrows a 32-bit register value to byte, halfword or word for memory writes.
- Replicates the narrowed value into the addressed byte lane(s) and generates byte enables.
- Flags truncation loss: the narrowed value would not sign- or zero-extend back to the original. Flags misalignment.
- Sits between the execute stage and the data-memory write port, with valid/ready handshakes on both sides.

---
 rtl/store_narrow_unit_pkg.sv | 21 ++
 rtl/store_lane_formatter.sv | 75 +++++++
 rtl/store_narrow_unit.sv | 136 +++++++++++++
 tb/tb_store_narrow_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the store narrowing unit.
//   - in_size encodings (byte / half / word / reserved)
//   - fmt_t: the formatted store fields produced by the lane formatter and
//     carried in each buffer entry alongside the word-aligned address.
package store_narrow_unit_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Formatted write payload; the address is added by the top level because
  // its width is a parameter of that module.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        misalign;
    logic        trunc;
  } fmt_t;

endpackage

// File: rtl/store_lane_formatter.sv
// Purely combinational store formatter.
//   data      in  32  register value to store
//   lane      in   2  byte address bits [1:0]
//   size      in   2  00 byte, 01 half, 10 word, 11 reserved
//   is_signed in   1  truncation check is signed when 1
//   wdata     out 32  value replicated across the byte lanes
//   be        out  4  byte enables (0 when misaligned)
//   misalign  out  1  misaligned access or reserved size
//   trunc     out  1  narrowed value does not extend back to data
module store_lane_formatter
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign,
  output logic        trunc
);

  // Lane replication, byte enables and error flags for one request.
  always_comb begin
    wdata    = data;
    be       = 4'b0000;
    misalign = 1'b0;
    trunc    = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << lane;
        // Signed: bits above the sign bit must all copy it.
        if (is_signed) begin
          trunc = (data[31:7] != 25'h0000000) && (data[31:7] != 25'h1FFFFFF);
        end else begin
          trunc = (data[31:8] != 24'h000000);
        end
      end
      SIZE_HALF: begin
        wdata    = {2{data[15:0]}};
        misalign = lane[0];
        if (lane[0]) begin
          be = 4'b0000;
        end else if (lane[1]) begin
          be = 4'b1100;
        end else begin
          be = 4'b0011;
        end
        if (is_signed) begin
          trunc = (data[31:15] != 17'h00000) && (data[31:15] != 17'h1FFFF);
        end else begin
          trunc = (data[31:16] != 16'h0000);
        end
      end
      SIZE_WORD: begin
        wdata    = data;
        misalign = (lane != 2'b00);
        if (lane != 2'b00) begin
          be = 4'b0000;
        end else begin
          be = 4'b1111;
        end
      end
      default: begin
        // Reserved size: formatted as a word but always flagged.
        wdata    = data;
        be       = 4'b0000;
        misalign = 1'b1;
        trunc    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: formats a 32-bit register value into byte/half/word
// memory writes and buffers it in a 2-entry skid buffer between the execute
// stage and the data-memory write port.
//   clk, reset                     clock, synchronous active-high reset
//   in_valid/in_ready              request handshake (in_ready registered)
//   in_data, in_addr, in_size,
//   in_signed                      request fields
//   out_valid/out_ready            write handshake
//   out_addr                       word-aligned address
//   out_wdata, out_be              lane-replicated data and byte enables
//   out_misalign, out_trunc        alignment/reserved-size and truncation flags
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wdata,
  output logic [3:0]        out_be,
  output logic              out_misalign,
  output logic              out_trunc
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    fmt_t              fmt;
  } entry_t;

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  fmt_t       fmt_s;
  entry_t     new_s;
  entry_t     head_r, skid_r, head_s, skid_s;
  logic [1:0] count_r, count_s;
  logic       in_ready_r, out_valid_r;
  logic       push_s, pop_s;

  store_lane_formatter u_fmt (
    .data      (in_data),
    .lane      (in_addr[1:0]),
    .size      (in_size),
    .is_signed (in_signed),
    .wdata     (fmt_s.wdata),
    .be        (fmt_s.be),
    .misalign  (fmt_s.misalign),
    .trunc     (fmt_s.trunc)
  );

  // Assemble the entry that would be written on an accept.
  always_comb begin
    new_s.addr = {in_addr[ADDR_W-1:2], 2'b00};
    new_s.fmt  = fmt_s;
  end

  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Next-state of the head/skid entries and the occupancy count.
  always_comb begin
    head_s  = head_r;
    skid_s  = skid_r;
    count_s = count_r;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          head_s  = new_s;
          count_s = 2'd1;
        end else begin
          count_s = 2'd0;
        end
      end
      2'd1: begin
        // Accept and drain together: the new entry becomes head directly.
        if (push_s && pop_s) begin
          head_s = new_s;
        end else if (push_s) begin
          skid_s  = new_s;
          count_s = 2'd2;
        end else if (pop_s) begin
          count_s = 2'd0;
        end else begin
          count_s = 2'd1;
        end
      end
      2'd2: begin
        // in_ready is low here, so only a drain can happen.
        if (pop_s) begin
          head_s  = skid_r;
          count_s = 2'd1;
        end else begin
          count_s = 2'd2;
        end
      end
      default: begin
        count_s = 2'd0;
      end
    endcase
  end

  // Buffer registers; in_ready and out_valid are registered from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r      <= '0;
      skid_r      <= '0;
      count_r     <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      head_r      <= head_s;
      skid_r      <= skid_s;
      count_r     <= count_s;
      in_ready_r  <= (count_s != FULL_CNT);
      out_valid_r <= (count_s != 2'd0);
    end
  end

  assign in_ready     = in_ready_r;
  assign out_valid    = out_valid_r;
  assign out_addr     = head_r.addr;
  assign out_wdata    = head_r.fmt.wdata;
  assign out_be       = head_r.fmt.be;
  assign out_misalign = head_r.fmt.misalign;
  assign out_trunc    = head_r.fmt.trunc;

endmodule

// File: tb/tb_store_narrow_unit.sv
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_misalign;
  logic        out_trunc;

  int n_checks = 0;
  int n_fail   = 0;

  store_narrow_unit #(.ADDR_W(32), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_addr      (in_addr),
    .in_size      (in_size),
    .in_signed    (in_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_be       (out_be),
    .out_misalign (out_misalign),
    .out_trunc    (out_trunc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_mis;
    logic        e_trunc;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_be, input logic e_mis, input logic e_trunc);
    chk({tag, " valid"},    {31'd0, out_valid},    32'd1);
    chk({tag, " addr"},     out_addr,              e_addr);
    chk({tag, " wdata"},    out_wdata,             e_wdata);
    chk({tag, " be"},       {28'd0, out_be},       {28'd0, e_be});
    chk({tag, " misalign"}, {31'd0, out_misalign}, {31'd0, e_mis});
    chk({tag, " trunc"},    {31'd0, out_trunc},    {31'd0, e_trunc});
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] a, input logic [1:0] s, input logic sg);
    in_valid  = 1'b1;
    in_data   = d;
    in_addr   = a;
    in_size   = s;
    in_signed = sg;
  endtask

  initial begin
    //            data          addr          sz     sg    e_addr        e_wdata       be       mis   trunc
    vecs[0]  = '{32'hFFFFFF80, 32'h00000103, 2'b00, 1'b1, 32'h00000100, 32'h80808080, 4'b1000, 1'b0, 1'b0};
    vecs[1]  = '{32'h00012345, 32'h00000202, 2'b01, 1'b1, 32'h00000200, 32'h23452345, 4'b1100, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000FFFF, 32'h00000202, 2'b01, 1'b0, 32'h00000200, 32'hFFFFFFFF, 4'b1100, 1'b0, 1'b0};
    vecs[3]  = '{32'h12345678, 32'h00000006, 2'b10, 1'b0, 32'h00000004, 32'h12345678, 4'b0000, 1'b1, 1'b0};
    vecs[4]  = '{32'hDEADBEEF, 32'h00000000, 2'b11, 1'b1, 32'h00000000, 32'hDEADBEEF, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{32'h000000FF, 32'h00000001, 2'b00, 1'b0, 32'h00000000, 32'hFFFFFFFF, 4'b0010, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000100, 32'h00000002, 2'b00, 1'b0, 32'h00000000, 32'h00000000, 4'b0100, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000007F, 32'h00000010, 2'b00, 1'b1, 32'h00000010, 32'h7F7F7F7F, 4'b0001, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000080, 32'h00000010, 2'b00, 1'b1, 32'h00000010, 32'h80808080, 4'b0001, 1'b0, 1'b1};
    vecs[9]  = '{32'hFFFF8000, 32'h00000020, 2'b01, 1'b1, 32'h00000020, 32'h80008000, 4'b0011, 1'b0, 1'b0};
    vecs[10] = '{32'h00001234, 32'h00000003, 2'b01, 1'b0, 32'h00000000, 32'h12341234, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{32'h80000000, 32'hABCD0008, 2'b10, 1'b1, 32'hABCD0008, 32'h80000000, 4'b1111, 1'b0, 1'b0};
    vecs[12] = '{32'h00010000, 32'h00000000, 2'b01, 1'b0, 32'h00000000, 32'h00000000, 4'b0011, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_addr = 32'd0;
    in_size = 2'b00; in_signed = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_addr",  out_addr,  32'd0);
    chk("rst out_wdata", out_wdata, 32'd0);
    chk("rst out_be",    {28'd0, out_be}, 32'd0);
    chk("rst flags",     {30'd0, out_misalign, out_trunc}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);

    // Formatting vectors, one per cycle with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].data, vecs[i].addr, vecs[i].size, vecs[i].sgn);
      @(posedge clk); #1;
      chk_head($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_wdata,
               vecs[i].e_be, vecs[i].e_mis, vecs[i].e_trunc);
      in_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("vec drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: 3 requests offered, only 2 accepted
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h11111111, 32'h00000010, 2'b10, 1'b0);
    @(posedge clk); #1;
    chk("bp in_ready after 1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    drive(32'h22222222, 32'h00000020, 2'b10, 1'b0);
    @(posedge clk); #1;
    chk("bp in_ready after 2", {31'd0, in_ready}, 32'd0);
    chk_head("bp head A", 32'h00000010, 32'h11111111, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    drive(32'h33333333, 32'h00000030, 2'b10, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp stall in_ready", {31'd0, in_ready}, 32'd0);
      chk_head("bp stall A", 32'h00000010, 32'h11111111, 4'b1111, 1'b0, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_head("bp head B", 32'h00000020, 32'h22222222, 4'b1111, 1'b0, 1'b0);
    chk("bp in_ready reopen", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk_head("bp head C", 32'h00000030, 32'h33333333, 4'b1111, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp no dup", {31'd0, out_valid}, 32'd0);

    // Streaming: one write per cycle, occupancy never above 1
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(32'hA0000000 + 32'(i), 32'h00000400 + 32'(4 * i), 2'b10, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("stream%0d wdata", i), out_wdata, 32'hA0000000 + 32'(i));
      chk($sformatf("stream%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream end out_valid", {31'd0, out_valid}, 32'd0);

    // Reset with two entries buffered
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'h55555555, 32'h00000040, 2'b10, 1'b0);
    @(negedge clk);
    drive(32'h66666666, 32'h00000044, 2'b10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid full in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst out_addr",  out_addr,  32'd0);
    chk("mid rst out_wdata", out_wdata, 32'd0);
    chk("mid rst be/flags",  {26'd0, out_be, out_misalign, out_trunc}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mid no stale", {31'd0, out_valid}, 32'd0);
      chk("mid in_ready", {31'd0, in_ready}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
